// File: rtl/proc_perf_pkg.sv
// Shared definitions for the processor performance-counter bank:
// the FSM state encoding, the default counter width and the event channel indices.
package proc_perf_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_COUNT  = 2'd1,
    ST_FROZEN = 2'd2
  } perf_state_t;

  localparam int DEF_CNT_W   = 32;
  localparam int DEF_NUM_EVT = 8;

  // Event channel assignment on the evt bus
  localparam int EVT_INST  = 0;
  localparam int EVT_ICREQ = 1;
  localparam int EVT_ICHIT = 2;
  localparam int EVT_DCREQ = 3;
  localparam int EVT_DCHIT = 4;

endpackage

// File: rtl/perf_cnt_slice.sv
// One performance counter with a sticky overflow flag.
// On overflow it either sticks at all-ones or wraps to zero, depending on SATURATE.
module perf_cnt_slice #(
  parameter int CNT_W    = 32,
  parameter int SATURATE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt,
  output logic             ovf
);

  localparam logic [CNT_W-1:0] ALL_ONES = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] ZERO     = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] ONE      = {{(CNT_W-1){1'b0}}, 1'b1};

  // Counter and sticky overflow; clear wins over increment
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= ZERO;
      ovf <= 1'b0;
    end else if (clr) begin
      cnt <= ZERO;
      ovf <= 1'b0;
    end else if (inc) begin
      if (cnt == ALL_ONES) begin
        ovf <= 1'b1;
        cnt <= (SATURATE != 0) ? ALL_ONES : ZERO;
      end else begin
        cnt <= cnt + ONE;
      end
    end
  end

endmodule

// File: rtl/perf_event_counter_bank.sv
// Bank of event counters plus a cycle counter for the pipelined core.
// Counts while running, freezes on Halt, clears on clr, and offers a
// registered read port selecting any counter (index NUM_EVT = cycle counter).
module perf_event_counter_bank
  import proc_perf_pkg::*;
#(
  parameter int NUM_EVT  = DEF_NUM_EVT,
  parameter int CNT_W    = DEF_CNT_W,
  parameter int SATURATE = 1,
  localparam int SEL_W   = $clog2(NUM_EVT + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               clr,
  input  logic [NUM_EVT-1:0] evt,
  input  logic               halt,
  input  logic [SEL_W-1:0]   rd_sel,
  output logic [CNT_W-1:0]   rd_data,
  output logic [NUM_EVT:0]   ovf,
  output logic               frozen,
  output logic               snap_valid
);

  perf_state_t      state;
  logic             counting;
  logic [CNT_W-1:0] cnt [NUM_EVT+1];
  logic [CNT_W-1:0] rd_next;

  // Slices only see increments in COUNT; their own clr input takes priority
  assign counting = (state == ST_COUNT);

  genvar g;
  generate
    for (g = 0; g < NUM_EVT; g++) begin : g_evt
      perf_cnt_slice #(
        .CNT_W    (CNT_W),
        .SATURATE (SATURATE)
      ) u_slice (
        .clk (clk),
        .rst (rst),
        .clr (clr),
        .inc (counting & evt[g]),
        .cnt (cnt[g]),
        .ovf (ovf[g])
      );
    end
  endgenerate

  perf_cnt_slice #(
    .CNT_W    (CNT_W),
    .SATURATE (SATURATE)
  ) u_cycle (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .inc (counting),
    .cnt (cnt[NUM_EVT]),
    .ovf (ovf[NUM_EVT])
  );

  // Run-control FSM with registered frozen flag and one-shot snapshot pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      frozen     <= 1'b0;
      snap_valid <= 1'b0;
    end else if (clr) begin
      state      <= ST_IDLE;
      frozen     <= 1'b0;
      snap_valid <= 1'b0;
    end else begin
      snap_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          frozen <= 1'b0;
          if (en) begin
            state <= ST_COUNT;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_COUNT: begin
          if (halt) begin
            state      <= ST_FROZEN;
            frozen     <= 1'b1;
            snap_valid <= 1'b1;
          end else if (!en) begin
            state  <= ST_IDLE;
            frozen <= 1'b0;
          end else begin
            state  <= ST_COUNT;
            frozen <= 1'b0;
          end
        end
        ST_FROZEN: begin
          state  <= ST_FROZEN;
          frozen <= 1'b1;
        end
        default: begin
          state  <= ST_IDLE;
          frozen <= 1'b0;
        end
      endcase
    end
  end

  // Read mux: out-of-range selects fall through to zero
  always_comb begin
    rd_next = {CNT_W{1'b0}};
    for (int i = 0; i <= NUM_EVT; i++) begin
      rd_next = rd_next | (cnt[i] & {CNT_W{rd_sel == SEL_W'(i)}});
    end
  end

  // Read data register: captures pre-update counter values
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data <= {CNT_W{1'b0}};
    end else begin
      rd_data <= rd_next;
    end
  end

endmodule

// File: tb/tb_perf_event_counter_bank.sv
// Self-checking bench: three bank instances (32-bit saturating, 4-bit
// saturating, 4-bit wrapping) share one stimulus stream; a behavioural model
// predicts every output each cycle, and literal reads pin the model.
module tb_perf_event_counter_bank;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       clr = 1'b0;
  logic [7:0] evt = 8'h00;
  logic       halt = 1'b0;
  logic [3:0] rd_sel = 4'd0;

  logic [31:0] rd_a;
  logic [3:0]  rd_b, rd_c;
  logic [8:0]  ovf_a, ovf_b, ovf_c;
  logic        frz_a, frz_b, frz_c;
  logic        snap_a, snap_b, snap_c;

  int vectors = 0;
  int miscompares = 0;
  int snap_seen = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  perf_event_counter_bank #(.NUM_EVT(8), .CNT_W(32), .SATURATE(1)) dut_a (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .evt(evt), .halt(halt), .rd_sel(rd_sel),
    .rd_data(rd_a), .ovf(ovf_a), .frozen(frz_a), .snap_valid(snap_a));
  perf_event_counter_bank #(.NUM_EVT(8), .CNT_W(4), .SATURATE(1)) dut_b (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .evt(evt), .halt(halt), .rd_sel(rd_sel),
    .rd_data(rd_b), .ovf(ovf_b), .frozen(frz_b), .snap_valid(snap_b));
  perf_event_counter_bank #(.NUM_EVT(8), .CNT_W(4), .SATURATE(0)) dut_c (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .evt(evt), .halt(halt), .rd_sel(rd_sel),
    .rd_data(rd_c), .ovf(ovf_c), .frozen(frz_c), .snap_valid(snap_c));

  // ---------------- behavioural model ----------------
  int              m_width [3] = '{32, 4, 4};
  bit              m_sat   [3] = '{1'b1, 1'b1, 1'b0};
  longint unsigned m_cnt   [3][9];
  bit              m_ovf   [3][9];
  longint unsigned m_rd    [3];
  int              m_mode;     // 0 idle, 1 counting, 2 frozen
  bit              m_snap;

  function automatic longint unsigned top_val(int w);
    return (64'd1 << w) - 64'd1;
  endfunction

  task automatic m_bump(int k, int j);
    if (m_cnt[k][j] == top_val(m_width[k])) begin
      m_ovf[k][j] = 1'b1;
      m_cnt[k][j] = m_sat[k] ? top_val(m_width[k]) : 64'd0;
    end else begin
      m_cnt[k][j] = m_cnt[k][j] + 64'd1;
    end
  endtask

  task automatic m_zero();
    for (int k = 0; k < 3; k++)
      for (int j = 0; j < 9; j++) begin
        m_cnt[k][j] = 64'd0;
        m_ovf[k][j] = 1'b0;
      end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_zero();
      for (int k = 0; k < 3; k++) m_rd[k] = 64'd0;
      m_mode = 0;
      m_snap = 1'b0;
    end else begin
      for (int k = 0; k < 3; k++)
        m_rd[k] = (rd_sel <= 4'd8) ? m_cnt[k][rd_sel] : 64'd0;
      m_snap = 1'b0;
      if (clr) begin
        m_zero();
        m_mode = 0;
      end else if (m_mode == 0) begin
        if (en) m_mode = 1;
      end else if (m_mode == 1) begin
        for (int k = 0; k < 3; k++) begin
          m_bump(k, 8);
          for (int j = 0; j < 8; j++) if (evt[j]) m_bump(k, j);
        end
        if (halt) begin
          m_mode = 2;
          m_snap = 1'b1;
        end else if (!en) begin
          m_mode = 0;
        end
      end
    end
  end

  function automatic logic [8:0] m_ovf_vec(int k);
    logic [8:0] v;
    for (int j = 0; j < 9; j++) v[j] = m_ovf[k][j];
    return v;
  endfunction

  task automatic cmp(string name, longint unsigned act, longint unsigned exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare of all instances against the model
  always @(negedge clk) begin
    if (chk_en) begin
      cmp("rd_a", rd_a, m_rd[0]);
      cmp("rd_b", rd_b, m_rd[1]);
      cmp("rd_c", rd_c, m_rd[2]);
      cmp("ovf_a", ovf_a, m_ovf_vec(0));
      cmp("ovf_b", ovf_b, m_ovf_vec(1));
      cmp("ovf_c", ovf_c, m_ovf_vec(2));
      cmp("frozen_a", frz_a, (m_mode == 2) ? 1 : 0);
      cmp("frozen_c", frz_c, (m_mode == 2) ? 1 : 0);
      cmp("snap_a", snap_a, m_snap);
      cmp("snap_b", snap_b, m_snap);
      if (snap_a) snap_seen++;
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #2;
    end
  endtask

  // Select a counter, let one edge latch it, check at the following negedge
  task automatic read_chk(string name, logic [3:0] sel, longint unsigned ea,
                          longint unsigned eb, longint unsigned ec);
    rd_sel = sel;
    tick();
    @(negedge clk);
    #1;
    cmp({name, "_a"}, rd_a, ea);
    cmp({name, "_b"}, rd_b, eb);
    cmp({name, "_c"}, rd_c, ec);
    @(posedge clk);
    #2;
  endtask

  initial begin
    tick(2);
    rst = 1'b0;
    chk_en = 1'b1;

    // 1: count evt[0] to 17, read it, then reset mid-count
    en = 1'b1; evt = 8'h01;
    tick();
    tick(17);
    evt = 8'h00; en = 1'b0;
    tick();
    read_chk("t1_cnt0", 4'd0, 64'd17, 64'd15, 64'd1);
    en = 1'b1; evt = 8'h01;
    tick(3);
    #1 rst = 1'b1;
    #1;
    cmp("t1_rst_rd", rd_a, 64'd0);
    cmp("t1_rst_ovf_b", ovf_b, 64'd0);
    cmp("t1_rst_frozen", frz_a, 64'd0);
    tick();
    rst = 1'b0; en = 1'b0; evt = 8'h00;
    tick();
    read_chk("t1_after_rst", 4'd0, 64'd0, 64'd0, 64'd0);

    // 2: evt=0x05 for 10 counting cycles
    en = 1'b1; evt = 8'h05;
    tick();
    tick(10);
    evt = 8'h00; en = 1'b0;
    tick();
    read_chk("t2_cnt0", 4'd0, 64'd10, 64'd10, 64'd10);
    read_chk("t2_cnt2", 4'd2, 64'd10, 64'd10, 64'd10);
    read_chk("t2_cnt1", 4'd1, 64'd0, 64'd0, 64'd0);
    read_chk("t2_cycle", 4'd8, 64'd11, 64'd11, 64'd11);

    // 3: halt on sixth counting cycle, then 20 frozen cycles with evt high
    clr = 1'b1; tick(); clr = 1'b0;
    en = 1'b1; evt = 8'h01;
    tick();
    tick(5);
    halt = 1'b1;
    tick();
    halt = 1'b0;
    @(negedge clk); #1;
    cmp("t3_snap", snap_a, 64'd1);
    cmp("t3_frozen", frz_a, 64'd1);
    @(posedge clk); #2;
    tick(20);
    read_chk("t3_cnt0", 4'd0, 64'd6, 64'd6, 64'd6);
    read_chk("t3_cycle", 4'd8, 64'd6, 64'd6, 64'd6);
    cmp("t3_snap_count", snap_seen, 64'd1);

    // 4: 17 evt[1] pulses overflow the 4-bit banks
    clr = 1'b1; tick(); clr = 1'b0;
    en = 1'b1; evt = 8'h02;
    tick();
    tick(17);
    evt = 8'h00; en = 1'b0;
    tick();
    read_chk("t4_cnt1", 4'd1, 64'd17, 64'd15, 64'd1);
    cmp("t4_ovf1_a", ovf_a[1], 64'd0);
    cmp("t4_ovf1_b", ovf_b[1], 64'd1);
    cmp("t4_ovf1_c", ovf_c[1], 64'd1);

    // 5: clr and halt together while counting
    clr = 1'b1; tick(); clr = 1'b0;
    en = 1'b1;
    tick();
    evt = 8'hFF;
    tick(3);
    clr = 1'b1; halt = 1'b1;
    tick();
    clr = 1'b0; halt = 1'b0; en = 1'b0; evt = 8'h00;
    tick();
    cmp("t5_frozen", frz_a, 64'd0);
    read_chk("t5_cycle", 4'd8, 64'd0, 64'd0, 64'd0);
    read_chk("t5_cnt7", 4'd7, 64'd0, 64'd0, 64'd0);
    cmp("t5_snap_count", snap_seen, 64'd1);

    // 6: cycle counter read, out-of-range select, en toggling holds counts
    en = 1'b1;
    tick();
    tick(4);
    en = 1'b0;
    tick();
    read_chk("t6_cycle", 4'd8, 64'd5, 64'd5, 64'd5);
    read_chk("t6_sel9", 4'd9, 64'd0, 64'd0, 64'd0);
    tick(5);
    read_chk("t6_hold", 4'd8, 64'd5, 64'd5, 64'd5);
    en = 1'b1;
    tick();
    tick(2);
    en = 1'b0;
    tick();
    read_chk("t6_resume", 4'd8, 64'd8, 64'd8, 64'd8);

    tick(2);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
